// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_arbiter_pkg: shared widths, access-width codes, arbiter states   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ram_arbiter_pkg;

  localparam int unsigned AddressWidth = 32;
  localparam int unsigned IDWidth      = 32;

  localparam logic [2:0] WIDTH_BYTE = 3'd0;
  localparam logic [2:0] WIDTH_HALF = 3'd1;
  localparam logic [2:0] WIDTH_WORD = 3'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2,
    ARB_IDROP = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_arbiter: shares the ramctrl port between fetch and data paths    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = AddressWidth,
  parameter int unsigned DATA_W       = IDWidth,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [DATA_W-1:0] if_data_out,
  input  logic              d_req_in,
  input  logic              d_rw_in,
  input  logic [2:0]        d_width_in,
  input  logic              d_sgn_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [DATA_W-1:0] d_wdata_in,
  output logic              d_done_out,
  output logic [DATA_W-1:0] d_rdata_out,
  output logic              ram_en_out,
  output logic              ram_rw_out,
  output logic              ram_sgn_out,
  output logic [2:0]        ram_width_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_wdata_out,
  input  logic              ram_rdy_in,
  input  logic [DATA_W-1:0] ram_rdata_in
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       w_grant_d;
  logic       w_grant_i;
  logic       w_if_fin;
  logic       w_d_fin;
  logic       w_ram_fin;
  logic       w_if_eligible;
  logic       w_pulse_pending;

  always_comb begin
    w_state_nxt     = r_state;
    w_starve_nxt    = r_starve_cnt;
    w_grant_d       = 1'b0;
    w_grant_i       = 1'b0;
    w_if_fin        = 1'b0;
    w_d_fin         = 1'b0;
    w_ram_fin       = 1'b0;
    w_if_eligible   = if_req_in & ~clear_in;
    // Requests seen during a done-pulse cycle are the old ones still held.
    w_pulse_pending = if_done_out | d_done_out;

    case (r_state)
      ARB_IDLE: begin
        if (!w_pulse_pending) begin
          if (d_req_in && !(w_if_eligible && (r_starve_cnt == STARVE_MAX))) begin
            w_grant_d   = 1'b1;
            w_state_nxt = ARB_DBUSY;
          end else if (w_if_eligible) begin
            w_grant_i   = 1'b1;
            w_state_nxt = ARB_IBUSY;
          end
        end
        if (w_grant_i || !if_req_in) begin
          w_starve_nxt = 4'd0;
        end else if (w_grant_d && (r_starve_cnt != STARVE_MAX)) begin
          w_starve_nxt = r_starve_cnt + 4'd1;
        end
      end
      ARB_IBUSY: begin
        if (clear_in) begin
          w_ram_fin   = ram_rdy_in;
          w_state_nxt = ram_rdy_in ? ARB_IDLE : ARB_IDROP;
        end else if (ram_rdy_in) begin
          w_ram_fin   = 1'b1;
          w_if_fin    = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_DBUSY: begin
        if (ram_rdy_in) begin
          w_ram_fin   = 1'b1;
          w_d_fin     = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_IDROP: begin
        if (ram_rdy_in) begin
          w_ram_fin   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state       <= ARB_IDLE;
      r_starve_cnt  <= 4'd0;
      if_done_out   <= 1'b0;
      if_data_out   <= '0;
      d_done_out    <= 1'b0;
      d_rdata_out   <= '0;
      ram_en_out    <= 1'b0;
      ram_rw_out    <= 1'b0;
      ram_sgn_out   <= 1'b0;
      ram_width_out <= 3'd0;
      ram_addr_out  <= '0;
      ram_wdata_out <= '0;
    end else if (rdy_in) begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if_done_out  <= w_if_fin;
      d_done_out   <= w_d_fin;
      if (w_if_fin) begin
        if_data_out <= ram_rdata_in;
      end
      if (w_d_fin) begin
        d_rdata_out <= ram_rdata_in;
      end
      if (w_grant_d) begin
        ram_en_out    <= 1'b1;
        ram_rw_out    <= d_rw_in;
        ram_sgn_out   <= d_sgn_in;
        ram_width_out <= d_width_in;
        ram_addr_out  <= d_addr_in;
        ram_wdata_out <= d_wdata_in;
      end else if (w_grant_i) begin
        ram_en_out    <= 1'b1;
        ram_rw_out    <= 1'b0;
        ram_sgn_out   <= 1'b0;
        ram_width_out <= WIDTH_WORD;
        ram_addr_out  <= if_addr_in;
        ram_wdata_out <= '0;
      end else if (w_ram_fin) begin
        ram_en_out <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_arbiter: directed self-checking bench for ram_arbiter         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ram_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        d_req_in;
  logic        d_rw_in;
  logic [2:0]  d_width_in;
  logic        d_sgn_in;
  logic [31:0] d_addr_in;
  logic [31:0] d_wdata_in;
  logic        d_done_out;
  logic [31:0] d_rdata_out;
  logic        ram_en_out;
  logic        ram_rw_out;
  logic        ram_sgn_out;
  logic [2:0]  ram_width_out;
  logic [31:0] ram_addr_out;
  logic [31:0] ram_wdata_out;
  logic        ram_rdy_in;
  logic [31:0] ram_rdata_in;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .if_req_in    (if_req_in),
    .if_addr_in   (if_addr_in),
    .if_done_out  (if_done_out),
    .if_data_out  (if_data_out),
    .d_req_in     (d_req_in),
    .d_rw_in      (d_rw_in),
    .d_width_in   (d_width_in),
    .d_sgn_in     (d_sgn_in),
    .d_addr_in    (d_addr_in),
    .d_wdata_in   (d_wdata_in),
    .d_done_out   (d_done_out),
    .d_rdata_out  (d_rdata_out),
    .ram_en_out   (ram_en_out),
    .ram_rw_out   (ram_rw_out),
    .ram_sgn_out  (ram_sgn_out),
    .ram_width_out(ram_width_out),
    .ram_addr_out (ram_addr_out),
    .ram_wdata_out(ram_wdata_out),
    .ram_rdy_in   (ram_rdy_in),
    .ram_rdata_in (ram_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are observed 1ns later.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    if_req_in = 1'b0; if_addr_in = '0;
    d_req_in = 1'b0; d_rw_in = 1'b0; d_width_in = 3'd0; d_sgn_in = 1'b0;
    d_addr_in = '0; d_wdata_in = '0;
    ram_rdy_in = 1'b0; ram_rdata_in = '0;
    tick(); tick();

    chk("rst_en",    ram_en_out,    0);
    chk("rst_ifdn",  if_done_out,   0);
    chk("rst_ddn",   d_done_out,    0);
    chk("rst_addr",  ram_addr_out,  0);
    chk("rst_state", dut.r_state,   0);
    chk("rst_cnt",   dut.r_starve_cnt, 0);
    rst_in = 1'b1;
    tick();

    // ramctrl pulse while idle must be ignored
    ram_rdy_in = 1'b1; ram_rdata_in = 32'h1111_1111;
    tick();
    chk("idle_rdy_ifdn", if_done_out, 0);
    chk("idle_rdy_ddn",  d_done_out,  0);
    ram_rdy_in = 1'b0;
    tick();

    // Lone fetch
    if_req_in = 1'b1; if_addr_in = 32'h100;
    tick();
    chk("f_en",    ram_en_out,    1);
    chk("f_addr",  ram_addr_out,  32'h100);
    chk("f_rw",    ram_rw_out,    0);
    chk("f_width", ram_width_out, 3'd2);
    tick(); tick();
    chk("f_en_hold", ram_en_out, 1);
    ram_rdy_in = 1'b1; ram_rdata_in = 32'hDEAD_BEEF;
    tick();
    chk("f_done", if_done_out, 1);
    chk("f_data", if_data_out, 32'hDEAD_BEEF);
    chk("f_en_lo", ram_en_out, 0);
    ram_rdy_in = 1'b0;
    tick();
    chk("f_pulse_1cyc", if_done_out, 0);
    chk("f_no_regrant", ram_en_out,  0);
    chk("f_idle",       dut.r_state, 0);
    if_req_in = 1'b0;
    tick();

    // Simultaneous fetch and data write: data first
    if_req_in = 1'b1; if_addr_in = 32'h200;
    d_req_in = 1'b1; d_rw_in = 1'b1; d_addr_in = 32'h2000; d_wdata_in = 32'h55; d_width_in = 3'd0;
    tick();
    chk("s_en",    ram_en_out,    1);
    chk("s_rw",    ram_rw_out,    1);
    chk("s_addr",  ram_addr_out,  32'h2000);
    chk("s_wdata", ram_wdata_out, 32'h55);
    chk("s_width", ram_width_out, 3'd0);
    chk("s_cnt",   dut.r_starve_cnt, 1);
    tick();
    ram_rdy_in = 1'b1; ram_rdata_in = 32'h0;
    tick();
    chk("s_ddone", d_done_out, 1);
    chk("s_en_lo", ram_en_out, 0);
    ram_rdy_in = 1'b0;
    tick();
    chk("s_gap_en", ram_en_out, 0);
    d_req_in = 1'b0;
    tick();
    chk("s_f_en",   ram_en_out,   1);
    chk("s_f_addr", ram_addr_out, 32'h200);
    chk("s_f_rw",   ram_rw_out,   0);
    chk("s_f_cnt",  dut.r_starve_cnt, 0);
    ram_rdy_in = 1'b1; ram_rdata_in = 32'h1234;
    tick();
    chk("s_f_done", if_done_out, 1);
    chk("s_f_data", if_data_out, 32'h1234);
    ram_rdy_in = 1'b0;
    tick();
    if_req_in = 1'b0;
    tick();

    // Starvation: four data grants, then fetch
    if_req_in = 1'b1; if_addr_in = 32'h300;
    d_req_in = 1'b1; d_rw_in = 1'b0; d_addr_in = 32'h4000; d_width_in = 3'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("st_d_addr", ram_addr_out, 32'h4000);
      chk("st_d_en",   ram_en_out,   1);
      chk("st_cnt",    dut.r_starve_cnt, k + 1);
      ram_rdy_in = 1'b1; ram_rdata_in = 32'hA0 + k;
      tick();
      chk("st_ddone", d_done_out,  1);
      chk("st_rdata", d_rdata_out, 32'hA0 + k);
      ram_rdy_in = 1'b0;
      tick();
      chk("st_gap_en", ram_en_out, 0);
    end
    tick();
    chk("st_f_addr", ram_addr_out, 32'h300);
    chk("st_f_rw",   ram_rw_out,   0);
    chk("st_f_cnt",  dut.r_starve_cnt, 0);
    ram_rdy_in = 1'b1; ram_rdata_in = 32'h3333;
    tick();
    chk("st_f_done", if_done_out, 1);
    ram_rdy_in = 1'b0;
    tick();
    if_req_in = 1'b0; d_req_in = 1'b0;
    tick();

    // Clear two cycles into a fetch; queued data granted after drop
    if_req_in = 1'b1; if_addr_in = 32'h500;
    tick();
    chk("c_en", ram_en_out, 1);
    tick();
    clear_in = 1'b1;
    d_req_in = 1'b1; d_rw_in = 1'b0; d_addr_in = 32'h6000; d_width_in = 3'd2;
    tick();
    chk("c_idrop", dut.r_state, 3);
    chk("c_en_hold", ram_en_out, 1);
    clear_in = 1'b0; if_req_in = 1'b0;
    tick();
    chk("c_en_hold2", ram_en_out, 1);
    ram_rdy_in = 1'b1; ram_rdata_in = 32'hBAD;
    tick();
    chk("c_en_lo",  ram_en_out,  0);
    chk("c_no_ifd", if_done_out, 0);
    chk("c_no_dd",  d_done_out,  0);
    ram_rdy_in = 1'b0;
    tick();
    chk("c_d_en",   ram_en_out,   1);
    chk("c_d_addr", ram_addr_out, 32'h6000);
    ram_rdy_in = 1'b1; ram_rdata_in = 32'hCAFE;
    tick();
    chk("c_d_done",  d_done_out,  1);
    chk("c_d_rdata", d_rdata_out, 32'hCAFE);
    ram_rdy_in = 1'b0;
    tick();
    d_req_in = 1'b0;
    tick();

    // Stall across ramctrl completion
    d_req_in = 1'b1; d_rw_in = 1'b0; d_addr_in = 32'h7000;
    tick();
    chk("h_en", ram_en_out, 1);
    rdy_in = 1'b0; ram_rdy_in = 1'b1; ram_rdata_in = 32'h7777;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("h_frz_en", ram_en_out, 1);
      chk("h_frz_dd", d_done_out, 0);
    end
    rdy_in = 1'b1;
    tick();
    chk("h_dd",    d_done_out,  1);
    chk("h_rdata", d_rdata_out, 32'h7777);
    chk("h_en_lo", ram_en_out,  0);
    ram_rdy_in = 1'b0; rdy_in = 1'b0;
    tick(); tick(); tick();
    chk("h_pulse_held", d_done_out, 1);
    rdy_in = 1'b1;
    tick();
    chk("h_pulse_clr", d_done_out, 0);
    chk("h_no_grant",  ram_en_out, 0);
    d_req_in = 1'b0;
    tick();

    // Reset in DBUSY
    d_req_in = 1'b1; d_rw_in = 1'b1; d_addr_in = 32'h8000; d_wdata_in = 32'h99; d_width_in = 3'd1;
    tick();
    chk("r_en", ram_en_out, 1);
    rst_in = 1'b0;
    tick();
    chk("r_en0",    ram_en_out,    0);
    chk("r_addr0",  ram_addr_out,  0);
    chk("r_wdata0", ram_wdata_out, 0);
    chk("r_rw0",    ram_rw_out,    0);
    chk("r_width0", ram_width_out, 0);
    chk("r_rdata0", d_rdata_out,   0);
    chk("r_state0", dut.r_state,   0);
    rst_in = 1'b1; d_req_in = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single RAM controller port between the instruction-fetch path and the data controller. It accepts one read request per cycle from fetch and one read or write request per cycle from the data side. It grants one at a time with a bounded-starvation priority scheme, drives the ramctrl transaction and returns a one-cycle completion pulse with read data to the winner. It sits between the fetch unit/data controller and ramctrl, and it also handles branch-mispredict clears so that stale responses are not delivered.

## Interface
- `ADDR_W`, 32: address width; matches `AddressWidth`.
- `DATA_W`, 32: data width; matches `IDWidth`.
- `STARVE_LIMIT`, 4: maximum consecutive data grants while a fetch request is pending; range 1..15.

- `clk_in` in 1: single clock; all state updates on the rising edge.
- `rst_in` in 1: reset, synchronous and active-low.
- `rdy_in` in 1: global enable; when low, all state and outputs hold.
- `clear_in` in 1: mispredict flush, one-cycle pulse.
- `if_req_in` in 1: fetch read request; level, held until `if_done_out` or clear.
- `if_addr_in` in ADDR_W: fetch address, word read.
- `if_done_out` out 1: one-cycle completion pulse to fetch.
- `if_data_out` out DATA_W: fetched word; valid with `if_done_out`.
- `d_req_in` in 1: data request; level, held until `d_done_out`.
- `d_rw_in` in 1: 1 = write, 0 = read.
- `d_width_in` in 3: access width code, passed through.
- `d_sgn_in` in 1: sign-extend on read, passed through.
- `d_addr_in` in ADDR_W: data address.
- `d_wdata_in` in DATA_W: store data.
- `d_done_out` out 1: one-cycle completion pulse to the data side.
- `d_rdata_out` out DATA_W: load data; valid with `d_done_out` when the request was a read.
- `ram_en_out` out 1: transaction active; level.
- `ram_rw_out`, `ram_sgn_out`, `ram_width_out[2:0]`, `ram_addr_out[ADDR_W]`, `ram_wdata_out[DATA_W]`: out; registered transaction fields.
- `ram_rdy_in` in 1: ramctrl completion pulse.
- `ram_rdata_in` in DATA_W: read data; valid with `ram_rdy_in`.

## Operation
- **States:**
  - `IDLE`: no transaction in flight.
  - `IBUSY`: a fetch transaction is in flight.
  - `DBUSY`: a data transaction is in flight.
  - `IDROP`: a fetch transaction was cleared; its response must be discarded.
- **Arbitration (IDLE, `rdy_in` high):**
  - Only `d_req_in` high: grant data.
  - Only `if_req_in` high: grant fetch.
  - Both high: grant data unless `starve_cnt == STARVE_LIMIT`, in which case grant fetch.
- **Starvation counter:**
  - `starve_cnt` increments on each data grant while `if_req_in` is high.
  - It resets to 0 on any fetch grant, and whenever `if_req_in` is low in IDLE.
  - It saturates at `STARVE_LIMIT`.
- **On grant:** latch the winner's fields into the `ram_*` registers, set `ram_en_out`, then go to IBUSY or DBUSY. Fetch grants drive `ram_rw_out` = 0, `ram_width_out` = word, `ram_sgn_out` = 0.
- **BUSY with `ram_rdy_in`:**
  - Clear `ram_en_out`.
  - Pulse the winner's done output for one cycle with `ram_rdata_in` registered onto its data output.
  - Return to IDLE.
- **`clear_in` handling:**
  - In IBUSY: go to IDROP. `ram_en_out` stays high until `ram_rdy_in`, then falls, with no `if_done_out`; return to IDLE.
  - In IDLE: suppresses a fetch grant that cycle; a data grant still proceeds.
  - Never affects DBUSY; stores and loads always complete.
- **Reset:** drives IDLE; `starve_cnt` = 0; `ram_en_out`, `if_done_out` and `d_done_out` = 0; all data/address outputs = 0. Reset mid-transaction abandons it silently (ramctrl shares the reset).

## Timing
- A request sampled high at edge N gives `ram_en_out` high after edge N.
- `ram_rdy_in` sampled at edge M gives done pulse high and `ram_en_out` low after edge M.
- The next grant can be sampled at edge M+1, so there is one idle bus cycle between transactions.
- Requesters must drop `*_req_in` in the cycle after the done pulse; the arbiter ignores `*_req_in` during the done-pulse cycle, so no double grant occurs.
- `ram_rdy_in` outside BUSY/IDROP is ignored.
- `ram_*` fields remain stable while `ram_en_out` is high.
- `rdy_in` low freezes everything, including done pulses: a pending pulse stays high until the first `rdy_in`-high edge clears it.

## Structure
- Shared package/header `constant.vh` holds `AddressWidth`, `IDWidth` and width codes (`WIDTH_WORD`). Add the state encoding localparams `ARB_IDLE`, `ARB_IBUSY`, `ARB_DBUSY`, `ARB_IDROP`.
- No sub-module is needed beyond an optional `starve_counter` (saturating counter with clear); a single module is preferred.

## Test plan
- **Lone fetch:** `if_req_in` with addr 0x100; ramctrl replies 3 cycles later with 0xDEADBEEF. Expect `ram_en_out` at N+1, `if_done_out` pulse with 0xDEADBEEF, then IDLE.
- **Simultaneous requests:** `if_req_in` and data write (addr 0x2000, 0x55, width byte) both high. Data is granted first with `ram_rw_out` = 1, and fetch is granted immediately after `d_done_out`.
- **Starvation:** `STARVE_LIMIT` = 4, data requests back-to-back with fetch held high. Exactly 4 data grants occur, then a fetch grant, then `starve_cnt` = 0.
- **Clear mid-fetch:** `clear_in` pulses two cycles into IBUSY. `ram_en_out` holds until `ram_rdy_in`, no `if_done_out` is seen, and a queued data request is granted next cycle.
- **Stall and reset:** `rdy_in` held low for 5 cycles across `ram_rdy_in` arrival. State is frozen and the pulse is delivered after resume. Separately, `rst_in` = 0 in DBUSY gives all outputs 0 and IDLE on the next edge.
